// File: rtl/arb_pkg.sv
// Shared sizing constants and state encoding for the 4-way round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int SEL_W   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;
endpackage : arb_pkg

// File: rtl/mux4_1_64bit.sv
// Plain 4:1 multiplexer for 64-bit payloads.
module mux4_1_64bit (
    input  logic [63:0] d0,
    input  logic [63:0] d1,
    input  logic [63:0] d2,
    input  logic [63:0] d3,
    input  logic [1:0]  sel,
    output logic [63:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule : mux4_1_64bit

// File: rtl/arb4_rr_64bit.sv
// Four-requester round-robin arbiter feeding a single registered output slot
// with valid/ready handshakes on both sides.
module arb4_rr_64bit
    import arb_pkg::*;
#(
    parameter int NUM_REQ = arb_pkg::NUM_REQ,
    parameter int DATA_W  = arb_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    input  logic [DATA_W-1:0]    req_data2,
    input  logic [DATA_W-1:0]    req_data3,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);
    arb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [SEL_W-1:0]    win_idx;
    logic [SEL_W-1:0]    cand;
    logic [DATA_W-1:0]   win_data;
    logic                accept_open;
    logic                grant;

    // Scan from the farthest offset back to ptr so the nearest valid index wins.
    always_comb begin
        win_idx = ptr_q;
        cand    = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = ptr_q + SEL_W'(k - 1);
            if (req_valid[cand]) begin
                win_idx = cand;
            end
        end
    end

    mux4_1_64bit u_payload_mux (
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .sel (win_idx),
        .y   (win_data)
    );

    assign accept_open = (state_q == EMPTY) || out_ready;
    assign grant       = !reset && accept_open && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (grant) begin
            state_d = FULL;
            ptr_d   = win_idx + 1'b1;
            sel_d   = win_idx;
            data_d  = win_data;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
endmodule : arb4_rr_64bit

// File: tb/tb_arb4_rr_64bit.sv
// Directed bench for arb4_rr_64bit with hand-computed expectations.
module tb_arb4_rr_64bit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    arb4_rr_64bit #(.NUM_REQ(4), .DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d, input logic [1:0] s);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".out_data"},  out_data, d);
        chk({tag, ".out_sel"},   64'(out_sel), 64'(s));
    endtask

    initial begin
        logic [3:0] exp_oh;

        // Reset with all requesters asserting
        reset     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        req_data0 = 64'hA0;
        req_data1 = 64'hA1;
        req_data2 = 64'hA2;
        req_data3 = 64'hA3;
        #2;
        chk("reset.req_ready", 64'(req_ready), 64'h0);
        tick();
        chk("reset.req_ready_hold", 64'(req_ready), 64'h0);
        chk_out("reset", 1'b0, 64'h0, 2'd0);
        reset = 1'b0;
        #1;

        // Rotation: grants 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << (i % 4);
            chk($sformatf("rr%0d.req_ready", i), 64'(req_ready), 64'(exp_oh));
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, 64'hA0 + 64'(i % 4), 2'(i % 4));
            #1;
        end
        // ptr is now 1

        // Pointer wrap: only req 3, then req 0 and 3
        req_valid = 4'b1000;
        req_data3 = 64'hDEAD_BEEF;
        #1;
        chk("wrap3.req_ready", 64'(req_ready), 64'h8);
        tick();
        chk_out("wrap3", 1'b1, 64'hDEAD_BEEF, 2'd3);
        req_valid = 4'b1001;
        #1;
        chk("wrap0.req_ready", 64'(req_ready), 64'h1);
        tick();
        chk_out("wrap0", 1'b1, 64'hA0, 2'd0);
        // ptr is now 1

        // Backpressure: load 0x1234 from req 1, then stall with req 2 waiting
        req_valid = 4'b0010;
        req_data1 = 64'h1234;
        #1;
        chk("bp_load.req_ready", 64'(req_ready), 64'h2);
        tick();
        chk_out("bp_load", 1'b1, 64'h1234, 2'd1);
        out_ready = 1'b0;
        req_valid = 4'b0100;
        req_data2 = 64'h5555_6666_7777_8888;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d.req_ready", i), 64'(req_ready), 64'h0);
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, 64'h1234, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release.req_ready", 64'(req_ready), 64'h4);
        tick();
        chk_out("bp_release", 1'b1, 64'h5555_6666_7777_8888, 2'd2);
        // ptr is now 3

        // Drain: nothing requesting
        req_valid = 4'b0000;
        #1;
        chk("drain.req_ready", 64'(req_ready), 64'h0);
        tick();
        chk_out("drain", 1'b0, 64'h5555_6666_7777_8888, 2'd2);
        tick();
        chk_out("drain_idle", 1'b0, 64'h5555_6666_7777_8888, 2'd2);

        // EMPTY accepts even with out_ready low; ptr 3 search order 3,0
        out_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("empty_fill.req_ready", 64'(req_ready), 64'h1);
        tick();
        chk_out("empty_fill", 1'b1, 64'hA0, 2'd0);
        // ptr is now 1

        // Reset mid-stream with req 2 about to be accepted
        out_ready = 1'b1;
        req_valid = 4'b0100;
        reset     = 1'b1;
        #1;
        chk("rst_mid.req_ready", 64'(req_ready), 64'h0);
        tick();
        chk_out("rst_mid", 1'b0, 64'h0, 2'd0);
        reset = 1'b0;
        // ptr back at 0 picks req 0; a stale ptr of 1 would pick req 2
        req_valid = 4'b0101;
        #1;
        chk("post_rst.req_ready", 64'(req_ready), 64'h1);
        tick();
        chk_out("post_rst", 1'b1, 64'hA0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_arb4_rr_64bit

// File: doc/arb4_rr_64bit.md
ARB4_RR_64BIT -- requirements
Module: arb4_rr_64bit

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; fixed at 4, selector width 2.
REQ-002 Parameter DATA_W, default 64: payload width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  bit i: requester i presents a payload.
REQ-006 req_data0..req_data3  input  64 each  payload of requester 0..3.
REQ-007 req_ready  output  4  bit i: requester i's payload is accepted this cycle; one-hot or zero.
REQ-008 out_valid  output  1  output register holds a valid payload.
REQ-009 out_data  output  64  registered payload.
REQ-010 out_sel  output  2  index of the requester whose payload occupies out_data.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-012 Handshake: a transfer occurs on any edge where valid and ready are both 1, on either side.
REQ-013 Requesters SHALL hold req_valid[i] and req_dataN stable until accepted; the block SHALL never make req_ready depend on out_data.
REQ-014 State machine: EMPTY (out_valid=0) and FULL (out_valid=1); out_valid equals (state==FULL).
REQ-015 Accept window: open when state==EMPTY, or state==FULL and out_ready==1 (drain and refill in the same cycle).
REQ-016 Arbitration: round-robin with pointer ptr[1:0]. Search order is ptr, ptr+1, ptr+2, ptr+3 mod 4. The first index with req_valid set is the winner.
REQ-017 req_ready[winner]=1 combinationally only while the accept window is open and at least one req_valid is set; otherwise req_ready=4'b0000.
REQ-018 On acceptance:
- out_data <= winner's payload (selected via a 2-bit mux select);
- out_sel <= winner;
- state <= FULL;
- ptr <= winner+1 mod 4 (3 wraps to 0).
REQ-019 Latency: an accepted payload appears on out_data/out_valid exactly one cycle after its handshake.
REQ-020 Throughput: with out_ready held at 1 and any req_valid set, one transfer per cycle.
REQ-021 FULL, out_ready=1, no req_valid: state <= EMPTY; out_data and out_sel hold their last values.
REQ-022 FULL, out_ready=0: out_data, out_sel and ptr hold; req_ready=0 (backpressure).
REQ-023 No acceptance in a cycle: ptr is unchanged.
REQ-024 Starvation bound: a requester holding req_valid is granted within 4 accept windows.
REQ-025 Reset has priority over every other event in the same cycle, including a pending handshake, which is dropped.

Reset
REQ-026 On reset=1 at a clock edge:
- state <= EMPTY, out_valid <= 0;
- out_data <= 64'h0, out_sel <= 2'b00;
- ptr <= 2'b00.
REQ-027 While reset=1, req_ready SHALL be 4'b0000.
REQ-028 Reset mid-operation discards the held payload without signalling a transfer.

Structure
REQ-029 Package arb_pkg SHALL hold NUM_REQ, DATA_W, SEL_W=2, and the state enum {EMPTY, FULL}.
REQ-030 The payload selector SHALL be one instance of the existing mux4_1_64bit, with sel driven by the winner index. Arbitration, pointer and output register are written in this module.

Verification
REQ-031 Reset check: assert reset with req_valid=4'b1111 -> req_ready=0; next cycle out_valid=0, out_data=0, out_sel=0.
REQ-032 Round-robin rotation:
- stimulus: req_valid=4'b1111, out_ready=1, data_i=64'hA0+i, from reset;
- required response: grants 0,1,2,3,0 on consecutive cycles;
- out_data is 64'hA0, A1, A2, A3 one cycle after each grant.
REQ-033 Pointer wrap: only req 3 valid (64'hDEAD_BEEF), then only req 0 and req 3 valid -> grant 3 then 0; ptr goes 3->0.
REQ-034 Backpressure:
- stimulus: FULL holding 64'h1234 from req 1, out_ready=0 for 5 cycles, req 2 valid;
- required response: out_data stays 64'h1234 and req_ready=0 throughout;
- on out_ready=1, req 2 is accepted the same cycle and out_data=req_data2 next cycle.
REQ-035 Drain: FULL, out_ready=1, no req_valid -> out_valid falls to 0 next cycle; out_data holds its value.
REQ-036 Reset mid-stream: reset during a handshake on req 2 -> the payload is not presented; the next grant after reset starts search at 0.
